frame_streamer: RTL

Transmit side for the row-averaging datapath. The block buffers one ROWS×COLS frame of 8-bit pixels, loaded through a random-access write port. On command it emits a one-cycle downstream reset pulse, then streams the frame one pixel per clock in row-major order. The averager has no input-valid and counts pixels from its own reset. This block therefore owns pixel-0 alignment: it drives the averager's reset and data inputs directly.

---
 rtl/frame_streamer.sv | 119 +++++++++++
 1 files changed

// File: rtl/frame_streamer.sv
// Frame buffer plus transmitter: pulses sync_rst, then streams ROWS*COLS pixels row-major.
// Optional FRAME_CHECKSUM_EN adds a 16-bit running sum of the streamed pixels on csum.
module frame_streamer #(
    parameter int ROWS = 16,
    parameter int COLS = 8,
    parameter int DW   = 8,
    parameter int AW   = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
`ifdef FRAME_CHECKSUM_EN
    output logic [15:0]   csum,
`endif
    output logic          sync_rst,
    output logic [DW-1:0] data,
    output logic          dvalid,
    output logic          busy,
    output logic          done
);

    localparam int NPIX = ROWS * COLS;
    localparam logic [AW:0] LAST = (AW+1)'(NPIX);

    typedef enum logic [1:0] {IDLE, SYNC, STREAM, DONE} state_t;

    state_t state_reg, state_next;

    logic [DW-1:0] mem [NPIX];
    logic [AW:0]   idx_reg;
    logic          wr_ok;

    logic          sync_rst_reg;
    logic [DW-1:0] data_reg;
    logic          dvalid_reg;
    logic          busy_reg;
    logic          done_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // idx_reg counts pixels already fetched; reaching LAST means the final pixel is on the bus.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SYNC;
            SYNC:    state_next = STREAM;
            STREAM:  if (idx_reg == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign wr_ok = wr_en && (state_reg == IDLE) && ({1'b0, wr_addr} < LAST);

    // Buffer contents survive reset, so no reset branch here.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Outputs are registered from the upcoming state so each lines up with its state cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_reg      <= '0;
            sync_rst_reg <= 1'b0;
            data_reg     <= '0;
            dvalid_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            sync_rst_reg <= (state_next == SYNC);
            dvalid_reg   <= (state_next == STREAM);
            busy_reg     <= (state_next != IDLE);
            done_reg     <= (state_next == DONE);
            if (state_next == STREAM) begin
                data_reg <= mem[idx_reg[AW-1:0]];
                idx_reg  <= idx_reg + 1'b1;
            end else begin
                data_reg <= '0;
                if (state_next == SYNC || state_next == IDLE) begin
                    idx_reg <= '0;
                end
            end
        end
    end

`ifdef FRAME_CHECKSUM_EN
    logic [15:0] csum_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            csum_reg <= '0;
        end else if (state_next == SYNC) begin
            csum_reg <= '0;
        end else if (dvalid_reg) begin
            csum_reg <= csum_reg + 16'(data_reg);
        end
    end

    assign csum = csum_reg;
`endif

    assign sync_rst = sync_rst_reg;
    assign data     = data_reg;
    assign dvalid   = dvalid_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule
